dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: number of consecutive lost arbitrations after which port 1 wins.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserting it forces reset state immediately, independent of clk.
REQ-004 p0_req, p1_req  in  1  access request, held until gnt.
REQ-005 p0_we, p1_we  in  1  1 = store, 0 = load.
REQ-006 p0_size, p1_size  in  2  00 byte, 01 half, 10 word; 11 treated as misaligned.
REQ-007 p0_addr, p1_addr  in  32  byte address.
REQ-008 p0_wdata, p1_wdata  in  32  store data, right-aligned.
REQ-009 p0_gnt, p1_gnt  out  1  one-cycle pulse: command accepted.
REQ-010 p0_rvalid, p1_rvalid  out  1  one-cycle completion pulse.
REQ-011 p0_rdata, p1_rdata  out  32  zero-extended, right-aligned load data; 0 for stores.
REQ-012 p0_err, p1_err  out  1  valid with rvalid; 1 = misaligned access.
REQ-013 mem_addr  out  11  word address, equal to latched addr[12:2].
REQ-014 mem_wd  out  32  lane-replicated write data.
REQ-015 mem_be  out  4  byte write enables to the synchronous RAM.
REQ-016 mem_rd  in  32  RAM read word, valid one cycle after mem_addr is presented.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one transaction in flight.
REQ-019 In IDLE with any req high, the winner's we/size/addr/wdata and port ID are latched, the winner's gnt pulses next cycle, and the FSM enters ISSUE.
REQ-020 Arbitration: p0 wins by default; p1 wins if its starve counter equals STARVE_MAX.
REQ-021 Starve counter: increments, saturating, when p1_req is high in IDLE and p0 wins; clears when p1 is granted or p1_req is low in IDLE.
REQ-022 Alignment: byte accepts any address; half requires addr[0]=0; word requires addr[1:0]=0.
REQ-023 Byte lanes: byte gives be = 1<<addr[1:0], wd = {4{wdata[7:0]}}; half gives be = addr[1]?1100:0011, wd = {2{wdata[15:0]}}; word gives be 1111, wd = wdata.
REQ-024 ISSUE: mem_addr and mem_wd are driven from latched values; mem_be = lane enables for an aligned store, else 0000; goes to WAIT for an aligned load, else DONE.
REQ-025 WAIT: mem_rd is captured and formatted into rdata (selected byte or half shifted to bit 0, upper bits 0); goes to DONE.
REQ-026 DONE: the latched port's rvalid pulses, with err = misaligned flag; the other port's rvalid stays 0; returns to IDLE.
REQ-027 Latency from IDLE sample: load gnt at +1, rvalid at +4; store or misaligned gnt at +1, rvalid at +3.
REQ-028 A misaligned access never writes memory (mem_be = 0000) and returns rdata 0, err 1.
REQ-029 mem_be is 0000 in every state except ISSUE.
REQ-030 mem_addr holds its last latched value outside ISSUE.
REQ-031 rdata is held until the next completion on the same port.
REQ-032 req changes outside IDLE are ignored; a req still high in IDLE after its gnt is a new request.
REQ-033 Both req high with counter below STARVE_MAX: p0 wins and p1 waits.

Reset
REQ-034 While reset is low: state IDLE; all gnt, rvalid, err and busy 0; all rdata 0; mem_be 0000; mem_addr 0; mem_wd 0; starve counter 0.
REQ-035 Reset asserted mid-transaction aborts it with no rvalid; a store aborted in ISSUE makes mem_be 0000 asynchronously.
REQ-036 After reset deasserts, the first arbitration occurs at the first rising edge with reset high.

Verification
REQ-037 p0 word store, addr 0x10, data 0xDEADBEEF; then word load of 0x10 -> mem_be 1111 and mem_addr 4 in ISSUE; load rvalid at +4 with rdata 0xDEADBEEF, err 0.
REQ-038 p1 byte store, addr 0x13, wdata 0xAB -> mem_be 1000, mem_wd 0xABABABAB; byte load of 0x13 returns 0x000000AB.
REQ-039 p0 half load at addr 0x22 with mem_rd = 0x12345678 -> rdata 0x00001234; half store at addr 0x21 -> mem_be stays 0000, rvalid at +3 with err 1, rdata 0.
REQ-040 p0 and p1 both request continuously -> p0 granted 4 times, then p1 once, then the pattern repeats; every grant has a matching rvalid on the correct port.
REQ-041 reset pulsed low during ISSUE of a p0 store -> mem_be drops to 0000 asynchronously; no rvalid; busy 0; the next request is served normally.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Two requester ports plus the synchronous RAM side of dm_arbiter.
// slave = arbiter view, master = requester/RAM environment view.
interface dm_arbiter_if;
  logic        p0_req, p1_req;
  logic        p0_we, p1_we;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt;
  logic        p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_err, p1_err;
  logic [10:0] mem_addr;
  logic [31:0] mem_wd;
  logic [3:0]  mem_be;
  logic [31:0] mem_rd;
  logic        busy;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_size, p1_size,
           p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rd,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
           p0_err, p1_err, mem_addr, mem_wd, mem_be, busy
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_size, p1_size,
           p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rd,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
           p0_err, p1_err, mem_addr, mem_wd, mem_be, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter with p1 starvation guard; one access in flight.
// Load: gnt +1, rvalid +4 cycles; store/misaligned: gnt +1, rvalid +3. Requests wait (held) until gnt.
module dm_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic        clk,
  input logic        reset,
  dm_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] starve;
  logic          lat_port, lat_we, lat_mis;
  logic [1:0]    lat_size;
  logic [12:0]   lat_addr;
  logic [31:0]   lat_wdata, ld_word;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0]   p0_rdata, p1_rdata;

  logic          p1_wins, sel_we, sel_mis;
  logic [1:0]    sel_size;
  logic [12:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wd, rd_shift, rd_fmt;

  assign p1_wins   = bus.p1_req && (!bus.p0_req || starve == CW'(STARVE_MAX));
  assign sel_we    = p1_wins ? bus.p1_we    : bus.p0_we;
  assign sel_size  = p1_wins ? bus.p1_size  : bus.p0_size;
  assign sel_addr  = p1_wins ? bus.p1_addr[12:0] : bus.p0_addr[12:0];
  assign sel_wdata = p1_wins ? bus.p1_wdata : bus.p0_wdata;

  always_comb begin
    sel_mis = 1'b1;
    case (sel_size)
      2'b00:   sel_mis = 1'b0;
      2'b01:   sel_mis = sel_addr[0];
      2'b10:   sel_mis = |sel_addr[1:0];
      default: sel_mis = 1'b1;
    endcase
  end

  always_comb begin
    lane_be = 4'b0000;
    lane_wd = lat_wdata;
    case (lat_size)
      2'b00: begin
        lane_be = 4'b0001 << lat_addr[1:0];
        lane_wd = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        lane_be = lat_addr[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{lat_wdata[15:0]}};
      end
      2'b10:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  end

  // Shifting by the byte offset brings the addressed byte/half down to bit 0.
  assign rd_shift = bus.mem_rd >> {lat_addr[1:0], 3'b000};

  always_comb begin
    rd_fmt = bus.mem_rd;
    case (lat_size)
      2'b00:   rd_fmt = {24'h0, rd_shift[7:0]};
      2'b01:   rd_fmt = {16'h0, rd_shift[15:0]};
      default: rd_fmt = bus.mem_rd;
    endcase
  end

  assign bus.mem_addr  = lat_addr[12:2];
  assign bus.mem_wd    = lane_wd;
  assign bus.mem_be    = (state == ISSUE && lat_we && !lat_mis) ? lane_be : 4'b0000;
  assign bus.busy      = (state != IDLE);
  assign bus.p0_gnt    = p0_gnt;
  assign bus.p1_gnt    = p1_gnt;
  assign bus.p0_rvalid = p0_rvalid;
  assign bus.p1_rvalid = p1_rvalid;
  assign bus.p0_err    = p0_err;
  assign bus.p1_err    = p1_err;
  assign bus.p0_rdata  = p0_rdata;
  assign bus.p1_rdata  = p1_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      starve    <= '0;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_mis   <= 1'b0;
      lat_size  <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ld_word   <= '0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      case (state)
        IDLE: begin
          // p1 only ages while it is actually waiting behind p0.
          if (!bus.p1_req || p1_wins)
            starve <= '0;
          else if (starve != CW'(STARVE_MAX))
            starve <= starve + 1'b1;
          if (bus.p0_req || bus.p1_req) begin
            lat_port  <= p1_wins;
            lat_we    <= sel_we;
            lat_mis   <= sel_mis;
            lat_size  <= sel_size;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            p0_gnt    <= !p1_wins;
            p1_gnt    <= p1_wins;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ld_word <= '0;
          state   <= (!lat_we && !lat_mis) ? WAIT : DONE;
        end
        WAIT: begin
          ld_word <= rd_fmt;
          state   <= DONE;
        end
        DONE: begin
          if (lat_port) begin
            p1_rvalid <= 1'b1;
            p1_err    <= lat_mis;
            p1_rdata  <= ld_word;
          end else begin
            p0_rvalid <= 1'b1;
            p0_err    <= lat_mis;
            p0_rdata  <= ld_word;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized bench for dm_arbiter against a byte-addressed memory / cycle-schedule model.
module tb_dm_arbiter;
  localparam int STARVE = 4;
  localparam int MAXC   = 8192;

  logic clk = 1'b0;
  logic reset = 1'b0;
  dm_arbiter_if bus();

  dm_arbiter #(.STARVE_MAX(STARVE)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_init(input int w);
    return 32'(w) * 32'h9E3779B1 ^ 32'h5A5A1234;
  endfunction

  // Synchronous RAM: byte-enabled write, registered read.
  logic [31:0] ram [0:2047];
  logic        ram_ok = 1'b0;
  always @(posedge clk) begin
    if (!ram_ok) begin
      for (int i = 0; i < 2048; i++) ram[i] <= ram_init(i);
      ram_ok <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wd[8*b +: 8];
    end
    bus.mem_rd <= ram[bus.mem_addr];
  end

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t q0[$], q1[$];
  logic gq[$];

  logic [7:0]  mref [0:8191];
  logic [1:0]  eg [MAXC];
  logic [1:0]  erv [MAXC];
  logic [1:0]  eerr [MAXC];
  logic        ebusy [MAXC];
  logic [3:0]  ebe [MAXC];
  logic [31:0] ewd [MAXC];
  logic [31:0] erd [MAXC];
  logic [10:0] eaddr [MAXC];
  logic        chk_addr [MAXC];
  logic [31:0] exp_rd0, exp_rd1;
  logic [12:0] undo_base;
  int          undo_nb;
  logic [7:0]  undo_old [4];
  int cyc, free_edge, losses;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      eg[c] = 0; erv[c] = 0; eerr[c] = 0; ebusy[c] = 0; ebe[c] = 0;
      ewd[c] = 0; erd[c] = 0; eaddr[c] = 0; chk_addr[c] = 0;
    end
  endtask

  task automatic model_txn(input int e, input int w, input req_t a);
    logic mis, load;
    int nb, rv;
    logic [12:0] base;
    logic [3:0] be;
    logic [31:0] wd, rd;
    mis  = (a.size == 2'b11) || (a.size == 2'b01 && a.addr[0]) ||
           (a.size == 2'b10 && a.addr[1:0] != 2'b00);
    nb   = (a.size == 2'b00) ? 1 : (a.size == 2'b01) ? 2 : 4;
    base = a.addr[12:0];
    load = !a.we && !mis;
    rv   = load ? e + 3 : e + 2;
    free_edge = rv + 1;
    eg[e][w] = 1'b1;
    for (int c = e; c < rv; c++) ebusy[c] = 1'b1;
    erv[rv][w]  = 1'b1;
    eerr[rv][w] = mis;
    chk_addr[e] = 1'b1;
    eaddr[e]    = base[12:2];
    rd = 0;
    if (a.we && !mis) begin
      be = 0;
      wd = 0;
      for (int i = 0; i < nb; i++) be[int'(base[1:0]) + i] = 1'b1;
      for (int k = 0; k < 4; k++) wd[8*k +: 8] = a.wdata[8*(k % nb) +: 8];
      ebe[e] = be;
      ewd[e] = wd;
      undo_base = base;
      undo_nb   = nb;
      for (int i = 0; i < nb; i++) begin
        undo_old[i] = mref[int'(base) + i];
        mref[int'(base) + i] = a.wdata[8*i +: 8];
      end
    end else if (load) begin
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = mref[int'(base) + i];
    end
    erd[rv] = rd;
  endtask

  task automatic drive();
    bus.p0_req = (q0.size() != 0);
    bus.p1_req = (q1.size() != 0);
    if (q0.size() != 0) begin
      bus.p0_we = q0[0].we; bus.p0_size = q0[0].size;
      bus.p0_addr = q0[0].addr; bus.p0_wdata = q0[0].wdata;
    end else begin
      bus.p0_we = 1'b0; bus.p0_size = 2'b00; bus.p0_addr = $urandom; bus.p0_wdata = $urandom;
    end
    if (q1.size() != 0) begin
      bus.p1_we = q1[0].we; bus.p1_size = q1[0].size;
      bus.p1_addr = q1[0].addr; bus.p1_wdata = q1[0].wdata;
    end else begin
      bus.p1_we = 1'b0; bus.p1_size = 2'b00; bus.p1_addr = $urandom; bus.p1_wdata = $urandom;
    end
  endtask

  task automatic check_cycle(input int c);
    if (bus.p0_gnt) gq.push_back(1'b0);
    if (bus.p1_gnt) gq.push_back(1'b1);
    check("gnt0", bus.p0_gnt, eg[c][0]);
    check("gnt1", bus.p1_gnt, eg[c][1]);
    check("rvalid0", bus.p0_rvalid, erv[c][0]);
    check("rvalid1", bus.p1_rvalid, erv[c][1]);
    if (erv[c][0]) begin exp_rd0 = erd[c]; check("err0", bus.p0_err, eerr[c][0]); end
    if (erv[c][1]) begin exp_rd1 = erd[c]; check("err1", bus.p1_err, eerr[c][1]); end
    check("rdata0", bus.p0_rdata, exp_rd0);
    check("rdata1", bus.p1_rdata, exp_rd1);
    check("busy", bus.busy, ebusy[c]);
    check("mem_be", bus.mem_be, ebe[c]);
    if (chk_addr[c]) check("mem_addr", bus.mem_addr, eaddr[c]);
    if (ebe[c] != 4'b0000) check("mem_wd", bus.mem_wd, ewd[c]);
  endtask

  // Present queued requests, predict the arbitration at the coming edge, then check.
  task automatic tick();
    logic r0, r1;
    int e, w;
    req_t a;
    drive();
    r0 = (q0.size() != 0);
    r1 = (q1.size() != 0);
    e  = cyc + 1;
    if (e >= free_edge) begin
      if (r0 || r1) begin
        w = (r1 && (!r0 || losses == STARVE)) ? 1 : 0;
        if (r1 && w == 0) losses = (losses < STARVE) ? losses + 1 : losses;
        else losses = 0;
        if (w == 1) a = q1.pop_front();
        else a = q0.pop_front();
        model_txn(e, w, a);
      end else begin
        losses = 0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle(cyc);
  endtask

  task automatic run_until_idle();
    while (q0.size() != 0 || q1.size() != 0 || cyc < free_edge) tick();
  endtask

  function automatic req_t mk(input logic we, input logic [1:0] sz,
                              input logic [31:0] ad, input logic [31:0] wd);
    req_t r;
    r.we = we; r.size = sz; r.addr = ad; r.wdata = wd;
    return r;
  endfunction

  function automatic req_t rnd_req();
    return mk(1'(($urandom % 2)), 2'($urandom_range(0, 3)),
              ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 63)), $urandom);
  endfunction

  initial begin
    logic [31:0] v;
    for (int w = 0; w < 2048; w++) begin
      v = ram_init(w);
      for (int k = 0; k < 4; k++) mref[4*w + k] = v[8*k +: 8];
    end
    clear_from(0);
    exp_rd0 = 0; exp_rd1 = 0;
    cyc = 0; free_edge = 0; losses = 0;
    drive();
    repeat (3) @(negedge clk);

    check("rst_gnt0", bus.p0_gnt, 0);
    check("rst_gnt1", bus.p1_gnt, 0);
    check("rst_rv0", bus.p0_rvalid, 0);
    check("rst_rv1", bus.p1_rvalid, 0);
    check("rst_err0", bus.p0_err, 0);
    check("rst_err1", bus.p1_err, 0);
    check("rst_rd0", bus.p0_rdata, 0);
    check("rst_rd1", bus.p1_rdata, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_be", bus.mem_be, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wd", bus.mem_wd, 0);

    reset = 1'b1;
    // Word store then load from p0; the store is issued on the first edge after reset release.
    q0.push_back(mk(1'b1, 2'b10, 32'h10, 32'hDEADBEEF));
    q0.push_back(mk(1'b0, 2'b10, 32'h10, 32'h0));
    run_until_idle();
    // Byte store/load on lane 3 from p1.
    q1.push_back(mk(1'b1, 2'b00, 32'h13, 32'h000000AB));
    q1.push_back(mk(1'b0, 2'b00, 32'h13, 32'h0));
    run_until_idle();
    // Upper half load, then a misaligned half store.
    q0.push_back(mk(1'b1, 2'b10, 32'h20, 32'h12345678));
    q0.push_back(mk(1'b0, 2'b01, 32'h22, 32'h0));
    q0.push_back(mk(1'b1, 2'b01, 32'h21, 32'h5555AAAA));
    run_until_idle();

    // Both ports saturated: p0 x4, p1 x1, repeating.
    gq.delete();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(rnd_req());
      q1.push_back(rnd_req());
    end
    run_until_idle();
    check("order_len", 32'(gq.size() >= 10), 1);
    for (int i = 0; i < 10; i++)
      if (i < gq.size()) check("order", 32'(gq[i]), 32'((i % 5) == 4));

    // Reset during ISSUE of a store: no write, no completion.
    q0.push_back(mk(1'b1, 2'b10, 32'h40, 32'hCAFEF00D));
    tick();
    #1 reset = 1'b0;
    #1;
    check("abort_be", bus.mem_be, 0);
    check("abort_busy", bus.busy, 0);
    for (int i = 0; i < undo_nb; i++) mref[int'(undo_base) + i] = undo_old[i];
    exp_rd0 = 0; exp_rd1 = 0; losses = 0;
    clear_from(cyc);
    repeat (2) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check("abort_rv0", bus.p0_rvalid, 0);
      check("abort_rv1", bus.p1_rvalid, 0);
      check("abort_busy2", bus.busy, 0);
    end
    reset = 1'b1;
    free_edge = 0;
    q0.push_back(mk(1'b0, 2'b10, 32'h40, 32'h0));
    run_until_idle();

    for (int t = 0; t < 600; t++) begin
      if (q0.size() < 2 && ($urandom % 2) == 0) q0.push_back(rnd_req());
      if (q1.size() < 2 && ($urandom % 2) == 0) q1.push_back(rnd_req());
      tick();
    end
    run_until_idle();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
